// File: rtl/syst_collector.sv
// Result sink for the bottom of a systolic MAC array: per-lane FIFOs absorb the
// column skew, and one aligned word per result row leaves over valid/ready.
module syst_collector #(
    parameter int N_LANES = 4,
    parameter int S_WIDTH = 32,
    parameter int DEPTH   = 8
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       enable,
    input  logic                       clear_i,
    input  logic [N_LANES*S_WIDTH-1:0] psumm_i,
    input  logic [N_LANES-1:0]         valid_i,
    output logic [N_LANES*S_WIDTH-1:0] data_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic                       stall_o,
    output logic                       overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_LVL  = CW'(DEPTH);
    localparam logic [CW-1:0] STALL_LVL = CW'(DEPTH - N_LANES);

    logic [S_WIDTH-1:0]         mem    [N_LANES][DEPTH];
    logic [AW-1:0]              wr_ptr [N_LANES];
    logic [AW-1:0]              rd_ptr [N_LANES];
    logic [CW-1:0]              cnt    [N_LANES];
    logic [N_LANES-1:0]         non_empty;
    logic [N_LANES-1:0]         near_full;
    logic [N_LANES-1:0]         wr_en;
    logic [N_LANES-1:0]         drop;
    logic [N_LANES*S_WIDTH-1:0] head_word;
    logic                       pop;

    always_comb begin
        non_empty = '0;
        near_full = '0;
        head_word = '0;
        for (int k = 0; k < N_LANES; k++) begin
            non_empty[k] = (cnt[k] != '0);
            near_full[k] = (cnt[k] >= STALL_LVL);
            head_word[k*S_WIDTH +: S_WIDTH] = mem[k][rd_ptr[k]];
        end
        pop = (&non_empty) && (!valid_o || ready_i);
        wr_en = '0;
        drop  = '0;
        // A full lane that pops this cycle frees a slot, so the write still lands.
        for (int k = 0; k < N_LANES; k++) begin
            wr_en[k] = valid_i[k] && enable && ((cnt[k] != FULL_LVL) || pop);
            drop[k]  = valid_i[k] && enable && (cnt[k] == FULL_LVL) && !pop;
        end
    end

    assign stall_o = |near_full;

    always_ff @(posedge clk) begin
        for (int k = 0; k < N_LANES; k++) begin
            if (!clear_i && wr_en[k]) begin
                mem[k][wr_ptr[k]] <= psumm_i[k*S_WIDTH +: S_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < N_LANES; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
                cnt[k]    <= '0;
            end
        end else if (clear_i) begin
            for (int k = 0; k < N_LANES; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
                cnt[k]    <= '0;
            end
        end else begin
            for (int k = 0; k < N_LANES; k++) begin
                if (wr_en[k]) begin
                    wr_ptr[k] <= wr_ptr[k] + AW'(1);
                end
                if (pop) begin
                    rd_ptr[k] <= rd_ptr[k] + AW'(1);
                end
                if (wr_en[k] && !pop) begin
                    cnt[k] <= cnt[k] + CW'(1);
                end else if (!wr_en[k] && pop) begin
                    cnt[k] <= cnt[k] - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_o     <= '0;
            valid_o    <= 1'b0;
            overflow_o <= 1'b0;
        end else if (clear_i) begin
            valid_o    <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            if (pop) begin
                data_o  <= head_word;
                valid_o <= 1'b1;
            end else if (ready_i) begin
                valid_o <= 1'b0;
            end
            if (|drop) begin
                overflow_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_syst_collector.sv
// Directed bench for syst_collector: skew realignment, enable gating,
// backpressure, overflow, signed data, clear and asynchronous reset.
module tb_syst_collector;

    logic         clk = 1'b0;
    logic         rstn;
    logic         enable;
    logic         clear_i;
    logic [127:0] psumm_i;
    logic [3:0]   valid_i;
    logic [127:0] data_o;
    logic         valid_o;
    logic         ready_i;
    logic         stall_o;
    logic         overflow_o;

    int total = 0;
    int bad   = 0;

    syst_collector #(.N_LANES(4), .S_WIDTH(32), .DEPTH(8)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .enable     (enable),
        .clear_i    (clear_i),
        .psumm_i    (psumm_i),
        .valid_i    (valid_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .stall_o    (stall_o),
        .overflow_o (overflow_o)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] w4(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c, input logic [31:0] d);
        return {d, c, b, a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rstn    = 1'b0;
        enable  = 1'b0;
        clear_i = 1'b0;
        psumm_i = '0;
        valid_i = '0;
        ready_i = 1'b0;
        tick();
        tick();
        chk("rst_valid", valid_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_stall", stall_o, 0);
        chk("rst_ovf", overflow_o, 0);
        rstn = 1'b1;
        tick();

        // skewed fill: lane k valid in cycle k
        enable  = 1'b1;
        ready_i = 1'b1;
        psumm_i = w4(100, 101, 102, 103);
        for (int c = 0; c < 4; c++) begin
            valid_i = 4'(1 << c);
            tick();
            chk($sformatf("skew_wait%0d", c), valid_o, 0);
        end
        valid_i = '0;
        tick();
        chk("skew_valid", valid_o, 1);
        chk("skew_data", data_o, w4(100, 101, 102, 103));
        tick();
        chk("skew_one_word", valid_o, 0);
        chk("skew_data_kept", data_o, w4(100, 101, 102, 103));

        // enable gating: lane 0 holds valid for 5 cycles, enable only in cycle 2
        psumm_i = w4(7, 7, 7, 7);
        for (int c = 0; c < 5; c++) begin
            enable  = (c == 2);
            valid_i = (c == 2) ? 4'hF : 4'h1;
            tick();
            chk($sformatf("gate_valid%0d", c), valid_o, (c == 3) ? 1 : 0);
            if (c == 3) chk("gate_data", data_o, w4(7, 7, 7, 7));
        end
        valid_i = '0;
        enable  = 1'b1;
        tick();
        chk("gate_no_dup", valid_o, 0);

        // backpressure: 6 rows with ready low
        ready_i = 1'b0;
        for (int r = 0; r < 6; r++) begin
            valid_i = 4'hF;
            psumm_i = w4(r*10, r*10+1, r*10+2, r*10+3);
            tick();
            chk($sformatf("bp_valid%0d", r), valid_o, (r >= 1) ? 1 : 0);
            if (r >= 1) chk($sformatf("bp_frozen%0d", r), data_o, w4(0, 1, 2, 3));
            chk($sformatf("bp_stall%0d", r), stall_o, (r >= 4) ? 1 : 0);
        end
        valid_i = '0;
        ready_i = 1'b1;
        for (int r = 1; r < 6; r++) begin
            tick();
            chk($sformatf("bp_row%0d", r), data_o, w4(r*10, r*10+1, r*10+2, r*10+3));
            chk($sformatf("bp_rowv%0d", r), valid_o, 1);
            if (r == 1) chk("bp_stall_hold", stall_o, 1);
        end
        chk("bp_stall_low", stall_o, 0);
        tick();
        chk("bp_drained", valid_o, 0);

        // overflow: lane 0 receives 9 writes into an 8-deep FIFO
        ready_i = 1'b0;
        valid_i = 4'h1;
        for (int i = 0; i < 9; i++) begin
            psumm_i = w4(200+i, 0, 0, 0);
            tick();
            chk($sformatf("ovf_flag%0d", i), overflow_o, (i == 8) ? 1 : 0);
        end
        valid_i = 4'hE;
        for (int j = 0; j < 8; j++) begin
            psumm_i = w4(0, 1000+j, 2000+j, 3000+j);
            tick();
        end
        valid_i = '0;
        chk("ovf_sticky", overflow_o, 1);
        chk("ovf_word0", data_o, w4(200, 1000, 2000, 3000));
        chk("ovf_word0v", valid_o, 1);
        ready_i = 1'b1;
        for (int j = 1; j < 8; j++) begin
            tick();
            chk($sformatf("ovf_word%0d", j), data_o, w4(200+j, 1000+j, 2000+j, 3000+j));
        end
        tick();
        chk("ovf_end", valid_o, 0);
        chk("ovf_still", overflow_o, 1);
        clear_i = 1'b1;
        valid_i = 4'hF;
        tick();
        clear_i = 1'b0;
        valid_i = '0;
        chk("clr_ovf", overflow_o, 0);
        chk("clr_valid", valid_o, 0);
        chk("clr_stall", stall_o, 0);
        tick();
        chk("clr_discard", valid_o, 0);

        // signed extremes pass through bit-exact
        valid_i = 4'hF;
        psumm_i = w4(32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0);
        tick();
        valid_i = '0;
        chk("sgn_wait", valid_o, 0);
        tick();
        chk("sgn_valid", valid_o, 1);
        chk("sgn_data", data_o, w4(32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0));
        tick();
        chk("sgn_end", valid_o, 0);

        // asynchronous reset with words buffered
        ready_i = 1'b0;
        valid_i = 4'hF;
        for (int r = 0; r < 4; r++) begin
            psumm_i = w4(50+r, 50+r, 50+r, 50+r);
            tick();
        end
        valid_i = '0;
        chk("ar_pre_valid", valid_o, 1);
        #3;
        rstn = 1'b0;
        #1;
        chk("ar_valid", valid_o, 0);
        chk("ar_stall", stall_o, 0);
        chk("ar_data", data_o, 0);
        tick();
        #2;
        rstn = 1'b1;
        ready_i = 1'b1;
        tick();
        chk("ar_empty", valid_o, 0);
        valid_i = 4'hF;
        psumm_i = w4(77, 77, 77, 77);
        tick();
        valid_i = '0;
        tick();
        chk("ar_new_valid", valid_o, 1);
        chk("ar_new_data", data_o, w4(77, 77, 77, 77));
        tick();
        chk("ar_no_old", valid_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/syst_collector.md
Name: syst_collector

Overview:
- Sink at the bottom of a systolic MAC array. Captures the per-column partial-sum result streams (psumm/valid pairs) leaving the last node row.
- Column k arrives k cycles after column 0. The block buffers each lane, realigns lanes into one output word per result row, and delivers words over a valid/ready handshake.
- Generates a stall request so the array controller can drop the shared enable before any lane buffer overflows.

Parameters:
- N_LANES, 4, number of array columns (lanes); >= 1.
- S_WIDTH, 32, signed partial-sum width per lane; matches node SO_WIDTH.
- DEPTH, 8, per-lane FIFO depth; power of two, DEPTH > N_LANES.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- enable  in  1  array-wide enable, the same net that drives the nodes.
- clear_i  in  1  synchronous flush.
- psumm_i  in  N_LANES*S_WIDTH  lane k at bits [k*S_WIDTH +: S_WIDTH]; signed.
- valid_i  in  N_LANES  per-lane result valid from the last node row.
- data_o  out  N_LANES*S_WIDTH  aligned result word; same packing as psumm_i.
- valid_o  out  1  data_o holds a word.
- ready_i  in  1  downstream accepts the word.
- stall_o  out  1  request to deassert enable.
- overflow_o  out  1  sticky lane-overflow flag.

Behaviour:
- Reset (rstn low, asynchronous): all FIFO pointers and counts = 0, valid_o = 0, data_o = 0, overflow_o = 0, stall_o = 0. Reset mid-transfer discards every buffered word.
- Capture: lane k writes psumm_i[k] into FIFO k at a rising edge when valid_i[k] & enable.
  - The node holds valid and data while enable is low, so samples taken with enable = 0 are ignored. This prevents duplicates.
  - Data is stored unmodified; there is no width conversion.
- Full lane: a write to a full lane is dropped, and overflow_o is set. overflow_o stays set until reset or clear_i. Other lanes continue normally.
- Pop condition: all N_LANES FIFOs non-empty AND (valid_o == 0 OR ready_i == 1).
  - A pop pops every lane together, loads data_o, and sets valid_o = 1.
  - If ready_i == 1 with valid_o == 1 and no pop is possible, valid_o clears to 0. data_o keeps its last value.
- Hold: while valid_o = 1 and ready_i = 0, data_o and valid_o are stable.
- Throughput: one word per cycle under continuous ready_i = 1.
- Latency: lane write at edge t → FIFO non-empty after t → pop at edge t+1 if the other lanes are already non-empty. valid_o is therefore high 2 edges after the slowest lane's valid_i is sampled.
- Simultaneous write and pop on one lane: both happen and the count is unchanged. A full lane that is also popping accepts the write, so there is no overflow.
- Pointers: wrap modulo DEPTH. Count range is 0..DEPTH.
- stall_o: combinational. Asserted when any lane count >= DEPTH - N_LANES. This leaves headroom for the up to N_LANES-1 skewed results still in flight, plus one.
- clear_i (synchronous, priority over capture and pop): empties all FIFOs, valid_o = 0, overflow_o = 0. Inputs in the same cycle are discarded.
- Lane ordering: words are aligned by per-lane arrival order only. The array guarantees every lane produces the same count of results per row.

Test Plan:
- Skewed fill: N_LANES=4, lane k drives value 100+k with valid high at cycle k, enable=1, ready_i=1 → exactly one word {103,102,101,100}. valid_o is high for one cycle, 2 edges after cycle 3.
- Enable gating: lane 0 holds valid_i=1 with value 7 for 5 cycles, enable=1 only in cycle 2; other lanes push 7 once → exactly one output word of 7s.
- Backpressure: stream 6 rows of values r*10+k with ready_i=0 → data_o frozen on the row-0 word. stall_o rises once lane 0's count reaches 4. Release ready_i → rows 0..5 appear in order, one per cycle, with no loss.
- Overflow: ready_i=0 and stall ignored, lane 0 writes 9 words (DEPTH=8) → overflow_o=1 after the 9th write and remains 1. The first 8 words are delivered intact. clear_i → overflow_o=0, valid_o=0, all FIFOs empty.
- Signed values: lanes carry -1 (all ones), -2^31, 2^31-1, 0 → data_o reproduces the bit patterns exactly.
- Async reset: assert rstn low mid-stream between edges with 3 words buffered → valid_o=0 and stall_o=0 immediately. After rstn rises, new input yields only new words.
